edge_detector_multi: RTL and testbench
======================================

# edge_detector_multi

Parametrised multi-channel edge detector for asynchronous or noisy single-bit inputs such as buttons, strobes and external flags. Each channel has:
- a synchroniser chain;
- a debounce filter;
- a selectable rising/falling/both-edge pulse generator;
- a sticky event flag with software clear.

Channel flags are OR-reduced into one interrupt line. The block sits between raw pins or cross-domain signals and the control logic that consumes single-cycle event pulses.

## Interface
Parameters:
- WIDTH, 8, number of independent channels (>=1)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DEBOUNCE, 4, consecutive stable cycles required before the filtered level changes (>=0; 0 = no filtering)

Ports. Clock `clk`; reset `rst` is synchronous and active-high. All logic is in the `clk` domain.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- data_in  in  WIDTH  raw channel inputs, may be asynchronous
- mode  in  2  edge select: 00 rise, 01 fall, 10 both, 11 pulses disabled
- clr  in  WIDTH  per-channel sticky clear, active-high, one cycle
- irq_en  in  WIDTH  per-channel interrupt enable
- level_out  out  WIDTH  debounced, synchronised channel level
- pulse_out  out  WIDTH  one-cycle edge event per channel
- sticky  out  WIDTH  latched events, held until cleared
- irq  out  1  |(sticky & irq_en), registered

## Operation
- Synchroniser: `data_in[i]` passes through SYNC_STAGES flops; the last stage is `sync[i]`.
- Debounce, per channel:
  - State: filtered `level[i]` and counter `cnt[i]`, width max(1, $clog2(DEBOUNCE+1)).
  - If `sync == level`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE-1`, or DEBOUNCE == 0: `level <= sync`, `cnt <= 0`, and a change event is raised.
  - Else: `cnt <= cnt + 1`.
  - A glitch shorter than DEBOUNCE cycles therefore never changes `level`. Any return to the old value restarts the count from 0.
- Edge qualification:
  - A change event to 1 is a rise; a change to 0 is a fall.
  - `pulse_out[i] <= event & ((mode==00 & rise) | (mode==01 & fall) | (mode==10))`.
  - mode 11 suppresses pulses, but `level` tracking continues.
  - `mode` is sampled on the same edge that commits the event.
- Sticky:
  - `sticky[i] <= (sticky[i] & ~clr[i]) | pulse_next[i]`.
  - Set and clear in the same cycle: set wins, so no event is lost.
- `irq` is registered from the next-state sticky and `irq_en`.
- Reset values: every sync flop, `level`, `cnt`, `pulse_out`, `sticky` and `irq` are 0.
  - Consequence: a channel held high through reset reports one rise after reset release, once the full latency has elapsed. This is intended.

## Timing
- Latency: an input change stable before edge 1 produces `pulse_out` high after edge SYNC_STAGES+DEBOUNCE+1, for exactly one cycle. Defaults: edge 7.
- `level_out` changes on the same edge that `pulse_out` rises.
- `sticky` rises on the same edge as `pulse_out`. `irq` rises on that same edge when `irq_en` is set.
- Clear: `clr` sampled high on edge N drops `sticky` after edge N. `irq` drops on the same edge N, unless another enabled sticky bit remains set.
- Minimum event spacing per channel: DEBOUNCE cycles (1 when DEBOUNCE=0). Each qualified level change yields one pulse; there is no coalescing.
- Reset asserted mid-count: `cnt` and `level` clear on that edge. Any pending event is discarded, with no pulse.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.

## Structure
- Shared package `edge_det_pkg`: mode encodings MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_OFF=2'b11.
- Sub-module `edge_chan`: one channel's synchroniser, debounce counter, level, qualification and sticky bit. It is parameterised by SYNC_STAGES and DEBOUNCE.
- Top level: a generate loop of WIDTH `edge_chan` instances, plus the registered `irq` reduction.

## Test plan
- Reset release with `data_in`=0, mode 00, defaults: all outputs stay 0 for 20 cycles, with no pulse.
- Clean rise on ch0 while mode 00: `pulse_out[0]` high for exactly 1 cycle after edge 7; `level_out[0]`=1 and `sticky[0]`=1 from the same edge. With `irq_en[0]`=1, `irq`=1 from the same edge.
- Glitch of 3 cycles on ch1 (DEBOUNCE=4): no pulse, `level_out[1]` stays 0. A 4-cycle pulse on ch1: exactly one rise pulse.
- Mode 01, then toggle ch2 0->1->0 with 10-cycle holds: only the fall produces a pulse. Mode 10: both edges pulse. Mode 11: no pulses, but `level_out[2]` still follows.
- `clr[3]` asserted in the same cycle a new ch3 pulse is committed: `sticky[3]` remains 1. A later `clr[3]` alone clears it, and `irq` drops on that same edge.
- `rst` asserted 2 cycles into a debounce count on ch4: no pulse ever issues for that transition. `level_out[4]`=0 until the input completes a fresh full-latency qualification after reset.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-select
// encodings and the edge qualification helper.
package edge_det_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } edge_mode_e;

  // Decides whether a filtered level change toward new_lvl is reported.
  function automatic logic edge_qualify(edge_mode_e m, logic chg, logic new_lvl);
    logic q;
    q = 1'b0;
    unique case (m)
      MODE_RISE: q = chg & new_lvl;
      MODE_FALL: q = chg & ~new_lvl;
      MODE_BOTH: q = chg;
      MODE_OFF:  q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: synchroniser, debounce filter, edge
// qualification and sticky event bit.
module edge_chan
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       level_out,
  output logic       pulse_out,
  output logic       sticky,
  output logic       sticky_nxt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   deb_level;
  logic                   change;
  logic                   pulse_nxt;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // With filtering, the debounced level is registered and the output stage
  // reports its change one edge later; without filtering the synchroniser
  // output feeds the output stage directly, keeping latency at
  // SYNC_STAGES+DEBOUNCE+1 in both cases.
  if (DEBOUNCE == 0) begin : g_nodeb
    assign deb_level = sync;
  end else begin : g_deb
    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt;
    logic          lvl;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign deb_level = lvl;
  end

  always_comb begin
    change     = deb_level ^ level_out;
    pulse_nxt  = edge_qualify(edge_mode_e'(mode), change, deb_level);
    sticky_nxt = (sticky & ~clr) | pulse_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_out <= 1'b0;
      pulse_out <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      level_out <= deb_level;
      pulse_out <= pulse_nxt;
      sticky    <= sticky_nxt;
    end
  end

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector: WIDTH independent channels plus a
// registered interrupt from enabled sticky flags.
module edge_detector_multi
  import edge_det_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clr,
  input  logic [WIDTH-1:0] irq_en,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] pulse_out,
  output logic [WIDTH-1:0] sticky,
  output logic             irq
);

  logic [WIDTH-1:0] sticky_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in[i]),
      .mode      (mode),
      .clr       (clr[i]),
      .level_out (level_out[i]),
      .pulse_out (pulse_out[i]),
      .sticky    (sticky[i]),
      .sticky_nxt(sticky_nxt[i])
    );
  end

  // Built from next-state sticky so irq moves on the same edge as sticky.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(sticky_nxt & irq_en);
  end

endmodule

// File: tb/tb_edge_detector_multi.sv
// Self-checking bench for edge_detector_multi: directed vector table,
// hand-written corner sequences and randomized traffic against a model.
module tb_edge_detector_multi;

  localparam int W   = 8;
  localparam int SS  = 2;
  localparam int DEB = 4;
  localparam int HD  = (DEB > 0) ? DEB : 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic [1:0]   mode;
  logic [W-1:0] clr;
  logic [W-1:0] irq_en;
  logic [W-1:0] level_out;
  logic [W-1:0] pulse_out;
  logic [W-1:0] sticky;
  logic         irq;

  edge_detector_multi #(
    .WIDTH      (W),
    .SYNC_STAGES(SS),
    .DEBOUNCE   (DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .mode     (mode),
    .clr      (clr),
    .irq_en   (irq_en),
    .level_out(level_out),
    .pulse_out(pulse_out),
    .sticky   (sticky),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: delay line for the synchroniser, a window of recent
  // synchronised samples for the filter, then the output stage.
  logic [W-1:0] m_dl   [SS];
  logic [W-1:0] m_hist [HD];
  logic [W-1:0] m_flev, m_lo, m_pulse, m_st;
  logic         m_irq;

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_dl[k] = '0;
    for (int k = 0; k < HD; k++) m_hist[k] = '0;
    m_flev = '0; m_lo = '0; m_pulse = '0; m_st = '0; m_irq = 1'b0;
  endtask

  task automatic model_update();
    logic [W-1:0] sync_cur, deb_cur, chg, pn, stn;
    bit all_diff;
    if (rst) begin
      model_reset();
      return;
    end
    sync_cur = m_dl[SS-1];
    deb_cur  = (DEB == 0) ? sync_cur : m_flev;
    chg      = deb_cur ^ m_lo;
    case (mode)
      2'b00:   pn = chg & deb_cur;
      2'b01:   pn = chg & ~deb_cur;
      2'b10:   pn = chg;
      default: pn = '0;
    endcase
    stn     = (m_st & ~clr) | pn;
    m_irq   = |(stn & irq_en);
    m_pulse = pn;
    m_st    = stn;
    m_lo    = deb_cur;
    if (DEB > 0) begin
      for (int k = HD - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = sync_cur;
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++)
          if (m_hist[k][i] == m_flev[i]) all_diff = 1'b0;
        if (all_diff) m_flev[i] = sync_cur[i];
      end
    end
    for (int k = SS - 1; k > 0; k--) m_dl[k] = m_dl[k-1];
    m_dl[0] = data_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Holds channel ch at v for n edges, counting its pulses.
  task automatic hold_ch(input int ch, input logic v, input int n, output int pulses);
    pulses = 0;
    data_in[ch] = v;
    for (int k = 0; k < n; k++) begin
      step();
      if (pulse_out[ch]) pulses++;
    end
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] clr;
    logic [W-1:0] lvl;
    logic [W-1:0] pls;
    logic [W-1:0] stk;
    logic         irq;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int np, nl, p1, p2;
    logic [W-1:0] flip;

    for (int r = 0; r < 6; r++) tbl[r] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 1'b1};
    tbl[7]  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 1'b1};
    tbl[8]  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 1'b1};
    tbl[9]  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 1'b1};
    tbl[10] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[11] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0};

    model_reset();
    rst = 1'b1; data_in = '0; mode = 2'b00; clr = '0; irq_en = '0;
    step(); step();
    chk("reset_state", {level_out, pulse_out, sticky, 7'b0, irq}, 32'h0);

    rst = 1'b0;
    nl = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if ({level_out, pulse_out, sticky, irq} != '0) nl++;
    end
    chk("idle_after_reset", nl, 0);

    // Clean rise on ch0 then a clear, one row per edge.
    irq_en = 8'h01;
    for (int r = 0; r < 12; r++) begin
      data_in = tbl[r].din;
      clr     = tbl[r].clr;
      step();
      chk($sformatf("tbl%0d_level", r),  level_out, tbl[r].lvl);
      chk($sformatf("tbl%0d_pulse", r),  pulse_out, tbl[r].pls);
      chk($sformatf("tbl%0d_sticky", r), sticky,    tbl[r].stk);
      chk($sformatf("tbl%0d_irq", r),    irq,       tbl[r].irq);
    end
    clr = '0;

    // Glitch rejection on ch1.
    data_in[1] = 1'b1;
    np = 0; nl = 0;
    for (int c = 0; c < 3; c++) begin
      step(); if (pulse_out[1]) np++; if (level_out[1]) nl++;
    end
    data_in[1] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step(); if (pulse_out[1]) np++; if (level_out[1]) nl++;
    end
    chk("glitch3_pulses", np, 0);
    chk("glitch3_level", nl, 0);
    data_in[1] = 1'b1;
    np = 0;
    for (int c = 0; c < 4; c++) begin step(); if (pulse_out[1]) np++; end
    data_in[1] = 1'b0;
    for (int c = 0; c < 16; c++) begin step(); if (pulse_out[1]) np++; end
    chk("pulse4_pulses", np, 1);

    // Edge selection on ch2.
    mode = 2'b01;
    hold_ch(2, 1'b1, 10, p1); hold_ch(2, 1'b0, 10, p2);
    chk("fall_mode_rise", p1, 0);
    chk("fall_mode_fall", p2, 1);
    mode = 2'b10;
    hold_ch(2, 1'b1, 10, p1); hold_ch(2, 1'b0, 10, p2);
    chk("both_mode_rise", p1, 1);
    chk("both_mode_fall", p2, 1);
    mode = 2'b11;
    hold_ch(2, 1'b1, 10, p1);
    chk("off_mode_level_hi", level_out[2], 1);
    hold_ch(2, 1'b0, 10, p2);
    chk("off_mode_level_lo", level_out[2], 0);
    chk("off_mode_pulses", p1 + p2, 0);

    // Set beats clear on ch3.
    mode = 2'b10; irq_en = 8'h08;
    hold_ch(3, 1'b1, 10, p1);
    chk("ch3_rise_sticky", sticky[3], 1);
    hold_ch(3, 1'b0, 6, p2);
    clr = 8'h08;
    step();
    clr = '0;
    chk("ch3_setwin_pulse", pulse_out[3], 1);
    chk("ch3_setwin_sticky", sticky[3], 1);
    chk("ch3_setwin_irq", irq, 1);
    step(); step(); step();
    clr = 8'h08;
    step();
    clr = '0;
    chk("ch3_clear_sticky", sticky[3], 0);
    chk("ch3_clear_irq", irq, 0);

    // Reset two cycles into a debounce count on ch4.
    mode = 2'b00;
    data_in[4] = 1'b1;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    np = 0; nl = 0;
    for (int c = 0; c < 6; c++) begin
      step(); if (pulse_out[4]) np++; if (level_out[4]) nl++;
    end
    chk("rst_mid_no_pulse", np, 0);
    chk("rst_mid_level_low", nl, 0);
    step();
    chk("rst_mid_fresh_pulse", pulse_out[4], 1);
    chk("rst_mid_fresh_level", level_out[4], 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      flip = '0;
      for (int i = 0; i < W; i++) flip[i] = ($urandom_range(0, 7) == 0);
      data_in = data_in ^ flip;
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) irq_en = W'($urandom);
      clr = W'($urandom & $urandom & $urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
      chk("rnd_level",  level_out, m_lo);
      chk("rnd_pulse",  pulse_out, m_pulse);
      chk("rnd_sticky", sticky,    m_st);
      chk("rnd_irq",    irq,       m_irq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
